// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the parametrised register file.
// Imported by the top and the read-port sub-module.
package regfile_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int NUM_REGS_DEF = 4;

    // Address width for a register count; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: zero/range checks, write bypass,
// output register and the RAW hazard term for this operand.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NUM_REGS  = NUM_REGS_DEF,
    parameter int ADDR_W    = addr_w(NUM_REGS),
    parameter int BYPASS_EN = 1,
    parameter int ZERO_REG  = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             rd_en,
    input  logic [ADDR_W-1:0]                rd_addr,
    input  logic                             wr_en,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
    input  logic [NUM_REGS-1:0]              busy,
    output logic [DATA_W-1:0]                rd_data,
    output logic                             hazard
);

    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

    logic              in_range;
    logic              is_zero;
    logic              addr_ok;
    logic              byp_hit;
    logic [DATA_W-1:0] rd_d;
    logic [DATA_W-1:0] rd_q;

    // Classify the address and detect same-cycle write forwarding.
    always_comb begin
        in_range = ({1'b0, rd_addr} < NUM_REGS_L);
        is_zero  = (ZERO_REG != 0) && (rd_addr == '0);
        addr_ok  = in_range && !is_zero;
        byp_hit  = (BYPASS_EN != 0) && wr_en && (wr_addr == rd_addr);
    end

    // Select the operand to capture and the hazard for this source.
    always_comb begin
        rd_d   = rd_q;
        hazard = 1'b0;
        if (addr_ok) begin
            hazard = busy[rd_addr] && !byp_hit;
        end
        if (rd_en) begin
            if (!addr_ok) begin
                rd_d = '0;
            end else if (byp_hit) begin
                rd_d = wr_data;
            end else begin
                rd_d = regs[rd_addr];
            end
        end
    end

    // Output register; holds when the port is not enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with two registered read ports and a
// per-register busy scoreboard for RAW stall detection in decode.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  DATA_W    = DATA_W_DEF,
    parameter int  NUM_REGS  = NUM_REGS_DEF,
    parameter int  BYPASS_EN = 1,
    parameter int  ZERO_REG  = 0,
    localparam int ADDR_W    = addr_w(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_en_a,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic                rd_en_b,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    input  logic                rsv_en,
    input  logic [ADDR_W-1:0]   rsv_addr,
    output logic [DATA_W-1:0]   ra,
    output logic [DATA_W-1:0]   rb,
    output logic [NUM_REGS-1:0] busy,
    output logic                stall
);

    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;
    logic [NUM_REGS-1:0]             busy_q;
    logic [NUM_REGS-1:0]             busy_d;
    logic                            wr_ok;
    logic                            rsv_ok;
    logic                            haz_a;
    logic                            haz_b;

    // Writes and reservations only act on real, writable registers.
    always_comb begin
        wr_ok  = wr_en && ({1'b0, wr_addr} < NUM_REGS_L)
                 && !((ZERO_REG != 0) && (wr_addr == '0));
        rsv_ok = rsv_en && ({1'b0, rsv_addr} < NUM_REGS_L)
                 && !((ZERO_REG != 0) && (rsv_addr == '0));
    end

    // Next array and scoreboard; a same-cycle reservation beats the clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    // Array and scoreboard state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    regfile_read_port #(
        .DATA_W    (DATA_W),
        .NUM_REGS  (NUM_REGS),
        .ADDR_W    (ADDR_W),
        .BYPASS_EN (BYPASS_EN),
        .ZERO_REG  (ZERO_REG)
    ) u_port_a (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rd_en_a),
        .rd_addr (rd_addr_a),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .regs    (regs_q),
        .busy    (busy_q),
        .rd_data (ra),
        .hazard  (haz_a)
    );

    regfile_read_port #(
        .DATA_W    (DATA_W),
        .NUM_REGS  (NUM_REGS),
        .ADDR_W    (ADDR_W),
        .BYPASS_EN (BYPASS_EN),
        .ZERO_REG  (ZERO_REG)
    ) u_port_b (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rd_en_b),
        .rd_addr (rd_addr_b),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .regs    (regs_q),
        .busy    (busy_q),
        .rd_data (rb),
        .hazard  (haz_b)
    );

    assign busy  = busy_q;
    assign stall = (rd_en_a && haz_a) || (rd_en_b && haz_b);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: three configurations driven in lockstep,
// table vectors, directed corner sequences and random traffic.
module tb_regfile_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en_a;
    logic [2:0] rd_addr_a;
    logic       rd_en_b;
    logic [2:0] rd_addr_b;
    logic       rsv_en;
    logic [2:0] rsv_addr;

    logic [7:0] ra0, rb0, ra1, rb1, ra2, rb2;
    logic [3:0] busy0, busy1;
    logic [5:0] busy2;
    logic       stall0, stall1, stall2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // d0: defaults, d1: no bypass, d2: six registers with hardwired zero
    regfile_scoreboard #(.DATA_W(8), .NUM_REGS(4), .BYPASS_EN(1), .ZERO_REG(0)) d0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr[1:0]),
        .wr_data(wr_data), .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a[1:0]),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b[1:0]), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr[1:0]), .ra(ra0), .rb(rb0), .busy(busy0), .stall(stall0));

    regfile_scoreboard #(.DATA_W(8), .NUM_REGS(4), .BYPASS_EN(0), .ZERO_REG(0)) d1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr[1:0]),
        .wr_data(wr_data), .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a[1:0]),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b[1:0]), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr[1:0]), .ra(ra1), .rb(rb1), .busy(busy1), .stall(stall1));

    regfile_scoreboard #(.DATA_W(8), .NUM_REGS(6), .BYPASS_EN(1), .ZERO_REG(1)) d2 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .ra(ra2), .rb(rb2), .busy(busy2), .stall(stall2));

    // ---------------- reference model ----------------
    logic [7:0] mreg  [3][8];
    logic [7:0] mbusy [3];
    logic [7:0] mra   [3];
    logic [7:0] mrb   [3];

    function automatic int nr(input int c);
        return (c == 2) ? 6 : 4;
    endfunction

    function automatic bit by(input int c);
        return c != 1;
    endfunction

    function automatic bit zr(input int c);
        return c == 2;
    endfunction

    function automatic int ma(input int c, input logic [2:0] a);
        logic [1:0] lo;
        lo = a[1:0];
        return (c == 2) ? int'(a) : int'(lo);
    endfunction

    function automatic bit mvalid(input int c, input int a);
        return (a < nr(c)) && !(zr(c) && a == 0);
    endfunction

    function automatic bit fwd(input int c, input int a);
        return by(c) && wr_en && (ma(c, wr_addr) == a);
    endfunction

    function automatic logic [7:0] mread(input int c, input int a);
        if (!mvalid(c, a)) return 8'h00;
        if (fwd(c, a)) return wr_data;
        return mreg[c][a];
    endfunction

    function automatic bit mhaz(input int c, input int a);
        return mvalid(c, a) && mbusy[c][a] && !fwd(c, a);
    endfunction

    function automatic bit mstall(input int c);
        return (rd_en_a && mhaz(c, ma(c, rd_addr_a)))
            || (rd_en_b && mhaz(c, ma(c, rd_addr_b)));
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 8; r++) mreg[c][r] = 8'h00;
            mbusy[c] = 8'h00;
            mra[c] = 8'h00;
            mrb[c] = 8'h00;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < 3; c++) begin
            int wa;
            int rs;
            logic [7:0] na;
            logic [7:0] nb;
            wa = ma(c, wr_addr);
            rs = ma(c, rsv_addr);
            na = mread(c, ma(c, rd_addr_a));
            nb = mread(c, ma(c, rd_addr_b));
            if (rd_en_a) mra[c] = na;
            if (rd_en_b) mrb[c] = nb;
            if (wr_en && mvalid(c, wa)) begin
                mreg[c][wa] = wr_data;
                mbusy[c][wa] = 1'b0;
            end
            if (rsv_en && mvalid(c, rs)) mbusy[c][rs] = 1'b1;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all();
        logic [7:0] ar [3];
        logic [7:0] br [3];
        logic [7:0] bz [3];
        logic       st [3];
        ar = '{ra0, ra1, ra2};
        br = '{rb0, rb1, rb2};
        bz = '{8'(busy0), 8'(busy1), 8'(busy2)};
        st = '{stall0, stall1, stall2};
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("d%0d_ra", c), 32'(ar[c]), 32'(mra[c]));
            chk($sformatf("d%0d_rb", c), 32'(br[c]), 32'(mrb[c]));
            chk($sformatf("d%0d_busy", c), 32'(bz[c]), 32'(mbusy[c]));
            chk($sformatf("d%0d_stall", c), 32'(st[c]), 32'(mstall(c)));
        end
    endtask

    // Called just after a rising edge: check, take the edge, land 1 after it.
    task automatic tick();
        #2;
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       ea;
        logic [2:0] aa;
        logic       eb;
        logic [2:0] ab;
        logic       re;
        logic [2:0] rs;
        logic [7:0] xra;
        logic [7:0] xrb;
        logic [3:0] xbusy;
        logic       xstall;
    } vec_t;

    function automatic vec_t mkv(input int we, input int wa, input int wd,
                                 input int ea, input int aa, input int eb, input int ab,
                                 input int re, input int rs, input int xra, input int xrb,
                                 input int xbusy, input int xstall);
        vec_t v;
        v.we = 1'(we);   v.wa = 3'(wa);   v.wd = 8'(wd);
        v.ea = 1'(ea);   v.aa = 3'(aa);
        v.eb = 1'(eb);   v.ab = 3'(ab);
        v.re = 1'(re);   v.rs = 3'(rs);
        v.xra = 8'(xra); v.xrb = 8'(xrb);
        v.xbusy = 4'(xbusy); v.xstall = 1'(xstall);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        wr_en = v.we;   wr_addr = v.wa;   wr_data = v.wd;
        rd_en_a = v.ea; rd_addr_a = v.aa;
        rd_en_b = v.eb; rd_addr_b = v.ab;
        rsv_en = v.re;  rsv_addr = v.rs;
    endtask

    task automatic idle();
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    vec_t tbl [13];

    initial begin
        // Expectations for d0 (bypass on, 4 regs): stall before the edge,
        // ra/rb/busy after it.
        tbl[0]  = mkv(1, 2, 'h5A, 0, 0, 0, 0, 0, 0, 'h00, 'h00, 'h0, 0);
        tbl[1]  = mkv(0, 0, 0,    1, 2, 0, 0, 0, 0, 'h5A, 'h00, 'h0, 0);
        tbl[2]  = mkv(1, 1, 'h33, 1, 1, 1, 1, 0, 0, 'h33, 'h33, 'h0, 0);
        tbl[3]  = mkv(0, 0, 0,    0, 0, 0, 0, 1, 3, 'h33, 'h33, 'h8, 0);
        tbl[4]  = mkv(0, 0, 0,    1, 3, 0, 0, 0, 0, 'h00, 'h33, 'h8, 1);
        tbl[5]  = mkv(1, 3, 'h7F, 1, 3, 0, 0, 0, 0, 'h7F, 'h33, 'h0, 0);
        tbl[6]  = mkv(1, 1, 'h44, 0, 0, 0, 0, 1, 1, 'h7F, 'h33, 'h2, 0);
        tbl[7]  = mkv(0, 0, 0,    1, 2, 1, 1, 0, 0, 'h5A, 'h44, 'h2, 1);
        tbl[8]  = mkv(1, 1, 'h99, 0, 0, 0, 0, 0, 0, 'h5A, 'h44, 'h0, 0);
        tbl[9]  = mkv(0, 0, 0,    0, 3, 0, 3, 1, 0, 'h5A, 'h44, 'h1, 0);
        tbl[10] = mkv(0, 0, 0,    0, 0, 0, 1, 0, 0, 'h5A, 'h44, 'h1, 0);
        tbl[11] = mkv(1, 0, 'h12, 1, 0, 0, 0, 0, 0, 'h12, 'h44, 'h0, 0);
        tbl[12] = mkv(0, 0, 0,    1, 1, 1, 3, 0, 0, 'h99, 'h7F, 'h0, 0);

        idle();
        reset = 1'b0;
        model_reset();
        #7;
        check_all();
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i]);
            #2;
            chk($sformatf("tbl%0d_stall", i), 32'(stall0), 32'(tbl[i].xstall));
            tick();
            chk($sformatf("tbl%0d_ra", i), 32'(ra0), 32'(tbl[i].xra));
            chk($sformatf("tbl%0d_rb", i), 32'(rb0), 32'(tbl[i].xrb));
            chk($sformatf("tbl%0d_busy", i), 32'(busy0), 32'(tbl[i].xbusy));
        end

        // Asynchronous reset between edges with a reservation pending.
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
        tick();
        idle();
        reset = 1'b0;
        #1;
        chk("arst_ra", 32'(ra0), 32'h0);
        chk("arst_rb", 32'(rb0), 32'h0);
        chk("arst_busy", 32'(busy0), 32'h0);
        chk("arst_busy2", 32'(busy2), 32'h0);
        model_reset();
        #1;
        reset = 1'b1;

        // Same-cycle write and read of reg1, with and without bypass.
        drive(mkv(1, 1, 'h33, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        tick();
        chk("nobyp_ra_old", 32'(ra1), 32'h0);
        chk("nobyp_rb_old", 32'(rb1), 32'h0);
        chk("byp_ra_new", 32'(ra0), 32'h33);
        drive(mkv(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk("nobyp_ra_next", 32'(ra1), 32'h33);

        // Hardwired zero register and out-of-range addresses on d2.
        drive(mkv(1, 0, 'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        drive(mkv(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk("zero_rd_d2", 32'(ra2), 32'h0);
        chk("zero_rd_d0", 32'(ra0), 32'hFF);
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tick();
        chk("zero_rsv_d2", 32'(busy2), 32'h0);
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0));
        tick();
        chk("oor_rsv_d2", 32'(busy2), 32'h0);
        drive(mkv(0, 0, 0, 1, 7, 1, 7, 0, 0, 0, 0, 0, 0));
        #2;
        chk("oor_stall_d2", 32'(stall2), 32'h0);
        chk("alias_stall_d0", 32'(stall0), 32'h1);
        tick();
        chk("oor_ra_d2", 32'(ra2), 32'h0);
        chk("oor_rb_d2", 32'(rb2), 32'h0);
        drive(mkv(1, 3, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();

        // Port A holds while disabled, even as its address and the array move.
        drive(mkv(1, 2, 'h6C, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk("hold_load", 32'(ra0), 32'h6C);
        for (int k = 0; k < 3; k++) begin
            drive(mkv(1, k + 1, 'hA0 + k, 0, k + 1, 0, 0, 0, 0, 0, 0, 0, 0));
            tick();
            chk($sformatf("hold%0d", k), 32'(ra0), 32'h6C);
        end

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            wr_en     = ($urandom_range(0, 99) < 40);
            wr_addr   = 3'($urandom_range(0, 7));
            wr_data   = 8'($urandom);
            rd_en_a   = ($urandom_range(0, 99) < 70);
            rd_addr_a = 3'($urandom_range(0, 7));
            rd_en_b   = ($urandom_range(0, 99) < 70);
            rd_addr_b = (n % 5 == 0) ? rd_addr_a : 3'($urandom_range(0, 7));
            rsv_en    = ($urandom_range(0, 99) < 35);
            rsv_addr  = (n % 7 == 0) ? wr_addr : 3'($urandom_range(0, 7));
            tick();
        end
        idle();
        #2;
        check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
